// File: rtl/gps_ack_pkg.sv
// Shared types and widths for the GPS acquisition sweep scheduler.
package gps_ack_pkg;

   localparam int PRN_W     = 5;
   localparam int BIN_W     = 5;
   localparam int INT_W_DEF = 12;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      EVAL,
      REPORT,
      DONE
   } state_t;

   // Per-PRN result record; peak is sized for the default integrator width.
   typedef struct packed {
      logic [PRN_W-1:0]     prn;
      logic [BIN_W-1:0]     bin;
      logic [INT_W_DEF-1:0] peak;
      logic                 found;
      logic                 timeout;
   } ack_result_t;

endpackage

// File: rtl/gps_ack_prn_pick.sv
// Priority encoder: lowest set mask bit above base (or at base when incl=1).
module gps_ack_prn_pick
   import gps_ack_pkg::*;
#(
   parameter int NUM_PRN = 32
) (
   input  logic [NUM_PRN-1:0] mask,
   input  logic [PRN_W-1:0]   base,
   input  logic               incl,
   output logic [PRN_W-1:0]   next_prn,
   output logic               valid
);

   // Scan downward so the last hit wins, leaving the lowest qualifying index.
   always_comb begin
      next_prn = '0;
      valid    = 1'b0;
      for (int i = NUM_PRN - 1; i >= 0; i--) begin
         if (mask[i] && ((i > int'(base)) || (incl && (i == int'(base))))) begin
            next_prn = PRN_W'(i);
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gps_ack_sched.sv
// Steps the acquisition engine over the PRN x Doppler grid and reports per-PRN peaks.
module gps_ack_sched
   import gps_ack_pkg::*;
#(
   parameter int NUM_PRN     = 32,
   parameter int NUM_BINS    = 21,
   parameter int INT_W       = INT_W_DEF,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [NUM_PRN-1:0] prn_mask,
   input  logic [INT_W-1:0]   threshold,
   output logic               ack_start,
   output logic [PRN_W-1:0]   sat0,
   output logic [BIN_W-1:0]   dop_bin,
   input  logic               ack_done,
   input  logic [INT_W-1:0]   integrator_0,
   output logic               busy,
   output logic               res_valid,
   output logic [PRN_W-1:0]   res_prn,
   output logic [BIN_W-1:0]   res_bin,
   output logic [INT_W-1:0]   res_peak,
   output logic               res_found,
   output logic               res_timeout,
   output logic               sweep_done
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BINS - 1);

   state_t             state;
   logic [NUM_PRN-1:0] mask_q;
   logic [INT_W-1:0]   thr_q;
   logic [PRN_W-1:0]   prn;
   logic [BIN_W-1:0]   bin;
   logic [WD_W-1:0]    wdog;
   logic [INT_W-1:0]   val;
   logic [INT_W-1:0]   peak;
   logic [BIN_W-1:0]   peak_bin;
   logic               to_flag;
   ack_result_t        res_q;

   logic [NUM_PRN-1:0] pick_mask;
   logic [PRN_W-1:0]   pick_base;
   logic               pick_incl;
   logic [PRN_W-1:0]   pick_next;
   logic               pick_valid;

   logic               upd;
   logic [INT_W-1:0]   new_peak;
   logic [BIN_W-1:0]   new_bin;

   // In IDLE the encoder looks at the live mask for the first PRN; afterwards it
   // walks the sampled mask upward from the current PRN.
   always_comb begin
      pick_mask = mask_q;
      pick_base = prn;
      pick_incl = 1'b0;
      if (state == IDLE) begin
         pick_mask = prn_mask;
         pick_base = '0;
         pick_incl = 1'b1;
      end
   end

   gps_ack_prn_pick #(.NUM_PRN(NUM_PRN)) u_pick (
      .mask     (pick_mask),
      .base     (pick_base),
      .incl     (pick_incl),
      .next_prn (pick_next),
      .valid    (pick_valid)
   );

   // Strict greater-than keeps the lowest bin on ties.
   always_comb begin
      upd      = (bin == '0) || (val > peak);
      new_peak = upd ? val : peak;
      new_bin  = upd ? bin : peak_bin;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         ack_start  <= 1'b0;
         res_valid  <= 1'b0;
         sweep_done <= 1'b0;
         mask_q     <= '0;
         thr_q      <= '0;
         prn        <= '0;
         bin        <= '0;
         wdog       <= '0;
         val        <= '0;
         peak       <= '0;
         peak_bin   <= '0;
         to_flag    <= 1'b0;
         res_q      <= '0;
      end else begin
         ack_start  <= 1'b0;
         res_valid  <= 1'b0;
         sweep_done <= 1'b0;
         if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     mask_q   <= prn_mask;
                     thr_q    <= threshold;
                     bin      <= '0;
                     peak     <= '0;
                     peak_bin <= '0;
                     to_flag  <= 1'b0;
                     if (pick_valid) begin
                        prn       <= pick_next;
                        busy      <= 1'b1;
                        ack_start <= 1'b1;
                        state     <= START;
                     end else begin
                        sweep_done <= 1'b1;
                        state      <= DONE;
                     end
                  end
               end
               START: begin
                  wdog  <= '0;
                  state <= WAIT;
               end
               WAIT: begin
                  if (ack_done) begin
                     val   <= integrator_0;
                     state <= EVAL;
                  end else if (wdog == WD_LAST) begin
                     val     <= '0;
                     to_flag <= 1'b1;
                     state   <= EVAL;
                  end else begin
                     wdog <= wdog + WD_W'(1);
                  end
               end
               EVAL: begin
                  peak     <= new_peak;
                  peak_bin <= new_bin;
                  if (bin == BIN_LAST) begin
                     res_q.prn     <= prn;
                     res_q.bin     <= new_bin;
                     res_q.peak    <= INT_W_DEF'(new_peak);
                     res_q.found   <= (new_peak >= thr_q);
                     res_q.timeout <= to_flag;
                     res_valid     <= 1'b1;
                     state         <= REPORT;
                  end else begin
                     bin       <= bin + BIN_W'(1);
                     ack_start <= 1'b1;
                     state     <= START;
                  end
               end
               REPORT: begin
                  peak     <= '0;
                  peak_bin <= '0;
                  to_flag  <= 1'b0;
                  bin      <= '0;
                  if (pick_valid) begin
                     prn       <= pick_next;
                     ack_start <= 1'b1;
                     state     <= START;
                  end else begin
                     sweep_done <= 1'b1;
                     state      <= DONE;
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign sat0        = prn;
   assign dop_bin     = bin;
   assign res_prn     = res_q.prn;
   assign res_bin     = res_q.bin;
   assign res_peak    = INT_W'(res_q.peak);
   assign res_found   = res_q.found;
   assign res_timeout = res_q.timeout;

endmodule
